// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings,
// default operand width and bit-counter sizing.
package serial_adder_pkg;

    localparam int SA_WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // counter must hold the value WIDTH after the last increment
    function automatic int sa_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell shared by the serial datapath.
// Purely combinational sum and carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // sum and carry of three one-bit inputs
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single cell.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = sa_cnt_w(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] ash;
    logic [WIDTH-1:0] bsh;
    logic [WIDTH-2:0] ssh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             is_idle;
    logic             is_add;
    logic             is_done;
    logic             last;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a  (ash[0]),
        .b  (bsh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // state decode and status outputs
    always_comb begin
        is_idle  = (state == ST_IDLE);
        is_add   = (state == ST_ADD);
        is_done  = (state == ST_DONE);
        last     = (cnt == CW'(WIDTH - 1));
        sum_next = {fa_s, ssh};
        busy     = ~is_idle;
        done     = is_done;
    end

    // FSM, operand shifters, carry flop and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ash   <= '0;
            bsh   <= '0;
            ssh   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                is_idle: begin
                    if (start) begin
                        ash   <= a;
                        bsh   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_ADD;
                    end
                end
                is_add: begin
                    ash   <= ash >> 1;
                    bsh   <= bsh >> 1;
                    ssh   <= sum_next[WIDTH-1:1];
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= sum_next;
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry flop holds the carry into the MSB here
                        ovf   <= carry ^ fa_co;
`endif
                        state <= ST_DONE;
                    end
                end
                is_done: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus
// corner sequences for busy-start, mid-op reset and back-to-back use.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt[8];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input vec_t v);
        bit ok;
        int n;
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        n     = cyc;
        tick();
        start = 1'b0;
        a     = ~v.a;
        b     = ~v.b;
        cin   = ~v.cin;
        wait_done(ok);
        chk({nm, "_lat"}, ok ? cyc - n : 0, 9);
        chk({nm, "_busy"}, {31'd0, busy}, 1);
        chk({nm, "_sum"}, {24'd0, sum}, {24'd0, v.s});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, v.co});
`ifdef SERIAL_ADDER_OVF_EN
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, v.ov});
`endif
        tick();
        chk({nm, "_pulse"}, {30'd0, done, busy}, 0);
        chk({nm, "_hold"}, {24'd0, sum}, {24'd0, v.s});
    endtask

    initial begin
        bit ok;
        bit seen;
        int n;
        int np;
        int p[4];
        int hold_bad;
        vec_t v;

        vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sum", {24'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i]);
        end

        // start during ADD is ignored
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        n     = cyc;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h22;
        cin   = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ok);
        chk("ign_lat", ok ? cyc - n : 0, 9);
        chk("ign_sum", {24'd0, sum}, 32'h10);
        chk("ign_cout", {31'd0, cout}, 0);
        tick();
        chk("ign_idle", {31'd0, busy}, 0);

        // reset in the 5th ADD cycle aborts
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_sum", {24'd0, sum}, 0);
        chk("abort_cout", {31'd0, cout}, 0);
        chk("abort_ovf", {31'd0, ovf}, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0) seen = 1'b1;
        end
        chk("abort_nopulse", {31'd0, seen}, 0);
        v = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        run_op("after_abort", v);

        // reset wins over start
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 0);
        tick();
        chk("rst_prio_idle", {31'd0, busy}, 0);

        // start held high: one result every WIDTH+2 cycles
        start    = 1'b1;
        a        = 8'h10;
        b        = 8'h20;
        cin      = 1'b0;
        n        = cyc;
        np       = 0;
        hold_bad = 0;
        for (int i = 0; i < 4; i++) p[i] = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (done === 1'b1) begin
                if (np < 4) p[np] = cyc;
                np++;
            end
            if (np > 0 && sum !== 8'h30) hold_bad++;
        end
        start = 1'b0;
        chk("bb_npulse", np, 3);
        chk("bb_first", p[0] - n, 9);
        chk("bb_gap1", p[1] - p[0], 10);
        chk("bb_gap2", p[2] - p[1], 10);
        chk("bb_hold", hold_bad, 0);
        for (int i = 0; i < 12; i++) tick();
        chk("bb_idle", {31'd0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, addend A; captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH, addend B; captured when start is accepted.
REQ-007 SHALL have port cin, input, 1, carry-in; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1, high in ADD and DONE states.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH, registered result; held until the next completion.
REQ-011 SHALL have port cout, output, 1, registered final carry; held until the next completion.
REQ-012 SHALL have port ovf, output, 1, signed overflow; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-014 In IDLE with start=1, SHALL load a, b into right-shift registers, cin into the carry flop, clear the bit counter and go to ADD.
REQ-015 In ADD, each cycle SHALL feed operand LSBs plus the carry flop into one full-adder cell.
REQ-016 In ADD, each cycle SHALL shift the sum bit into the MSB of an internal sum shift register, store the cell carry-out in the carry flop and increment the counter.
REQ-017 After exactly WIDTH ADD cycles, SHALL go to DONE.
REQ-018 On entering DONE, SHALL register the complete sum into sum and the final carry into cout.
REQ-019 In DONE, SHALL drive done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: done is high in cycle N+WIDTH+1, where N is the cycle in which start was accepted.
REQ-021 SHALL ignore start while busy=1, including the DONE cycle; the in-flight operation is unaffected.
REQ-022 SHALL accept a start in the cycle immediately after done; peak throughput is one result per WIDTH+2 cycles.
REQ-023 The result SHALL equal the low WIDTH bits of a+b+cin, with cout as bit WIDTH; wrap-around is modulo 2^WIDTH.
REQ-024 a, b and cin changing after acceptance SHALL NOT affect the result.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and clear busy, done, sum, cout, ovf, the counter, the carry flop and the shift registers to 0.
REQ-026 Reset mid-operation SHALL abort it with no done pulse and no update to sum or cout beyond the clear.
REQ-027 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN defined: SHALL capture the carry into the MSB during the last ADD cycle.
REQ-029 Macro SERIAL_ADDER_OVF_EN defined: SHALL register ovf = carry-into-MSB XOR cout, updated together with sum.
REQ-030 Macro SERIAL_ADDER_OVF_EN undefined: the ovf port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-031 A shared package serial_adder_pkg SHALL hold the FSM state encodings, the WIDTH default and the counter width, clog2(WIDTH)+1.
REQ-032 The one-bit sum/carry cell SHALL be the existing full_adder module, instantiated exactly once as the sole sub-module; no other adder logic is permitted.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, a=0x0F b=0x01 cin=0 -> done exactly 9 cycles after the start cycle, sum=0x10 cout=0.
REQ-034 The bench SHALL cover: a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; ovf=0 when enabled.
REQ-035 The bench SHALL cover: a=0x7F b=0x00 cin=1 -> sum=0x80 cout=0; ovf=1 when enabled.
REQ-036 The bench SHALL cover: start pulsed in the 3rd ADD cycle with different operands -> ignored, and the first result is delivered unchanged.
REQ-037 The bench SHALL cover: rst asserted in the 5th ADD cycle -> no done pulse, all outputs 0; the next start with a=0x01 b=0x01 yields sum=0x02.
REQ-038 The bench SHALL cover: start held high continuously -> done pulses every 10 cycles, and sum holds between pulses.
